rd_side_ctrl: RTL and testbench
===============================

RD_SIDE_CTRL -- requirements
Module: rd_side_ctrl

Interface
REQ-001 The block SHALL have parameter ADDRSIZE, default 4, meaning the FIFO memory address width (depth = 2^ADDRSIZE).
REQ-002 The block SHALL have parameter DATASIZE, default 8, meaning the data word width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; the clock and reset ports SHALL be named rclk and rst as in the rest of the codebase.
REQ-004 rclk  input  1  read-domain clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 rq2_wptr  input  ADDRSIZE+1  gray-coded write pointer, already two-flop synchronized into rclk.
REQ-007 rptr  output  ADDRSIZE+1  registered gray-coded read pointer, sent to the write domain.
REQ-008 raddr  output  ADDRSIZE  memory read address, equal to the low ADDRSIZE bits of the binary read pointer.
REQ-009 ren  output  1  memory read strobe; the memory SHALL return data on mem_rdata one cycle after ren.
REQ-010 mem_rdata  input  DATASIZE  memory read data, valid the cycle after ren.
REQ-011 rempty  output  1  registered FIFO-empty flag as seen by the read domain.
REQ-012 rcount  output  ADDRSIZE+1  registered word count still in memory, as seen by the read domain.
REQ-013 dout  output  DATASIZE  head-of-queue data to the consumer.
REQ-014 dout_valid  output  1  dout holds a valid word.
REQ-015 dout_ready  input  1  the consumer accepts dout; a transfer occurs when dout_valid and dout_ready are both 1.

Function
REQ-016 rbin (ADDRSIZE+1 bits) SHALL increment by 1 on every cycle with ren=1, wrapping modulo 2^(ADDRSIZE+1).
REQ-017 rptr SHALL be registered as (rbin_next >> 1) ^ rbin_next.
REQ-018 rempty SHALL be registered as (gray(rbin_next) == rq2_wptr).
REQ-019 rcount SHALL be registered as (bin(rq2_wptr) - rbin_next) mod 2^(ADDRSIZE+1).
  - bin() is the combinational gray-to-binary conversion.
  - rcount SHALL never exceed 2^ADDRSIZE.
REQ-020 The output stage SHALL be a 2-entry in-order buffer (head plus skid) with occupancy occ (0..2) and an in-flight flag inflt (1 in the cycle after ren).
REQ-021 The ren equation SHALL be: ren = !rempty && (occ + inflt - pop) < 2, where pop = dout_valid && dout_ready.
REQ-022 ren SHALL be combinational from registered state and dout_ready; it SHALL never assert while rempty=1.
REQ-023 When inflt=1, mem_rdata SHALL be written into the buffer in that same cycle.
REQ-024 occ_next SHALL equal occ + inflt - pop.
REQ-025 dout SHALL always present the oldest buffered word, and dout_valid SHALL equal (occ != 0).
REQ-026 Simultaneous pop and arrival SHALL preserve order with no loss or duplication; with occ=1, pop and arrival, the new word SHALL become head in the next cycle.
REQ-027 When occ=2 and dout_ready=0, dout and dout_valid SHALL be held stable.
REQ-028 Steady-state throughput SHALL be one word per cycle when the FIFO is non-empty and dout_ready=1.
REQ-029 Latency from rempty falling to dout_valid SHALL be 2 cycles: ren in cycle N, data arrives in N+1, dout_valid=1 in N+2.
REQ-030 Wrap-around: crossing raddr from 2^ADDRSIZE-1 to 0 SHALL toggle the rbin MSB and SHALL need no special handling.

Reset
REQ-031 While rst=0, the block SHALL asynchronously set rbin=0, rptr=0, rempty=1, rcount=0, occ=0, inflt=0, dout_valid=0 and dout=0; ren SHALL be 0.
REQ-032 After rst deasserts, the first update SHALL occur on the next rising edge of rclk.
REQ-033 Reset asserted mid-transfer SHALL discard buffered and in-flight words; a mem_rdata value arriving after reset SHALL be ignored.

Verification
REQ-034 Reset, rq2_wptr=0 held -> rempty=1, ren=0, dout_valid=0, rcount=0 indefinitely.
REQ-035 rq2_wptr steps to gray(3)=00010, dout_ready=1 -> ren high for 3 cycles; dout_valid from the 2nd cycle after the first ren; 3 words delivered in order; rptr ends 00010; rempty=1.
REQ-036 FIFO holds 16 words, dout_ready=0 -> exactly 2 reads issued, occ=2, rcount=14; then dout_ready=1 -> 1 word per cycle, 16 words total, no duplicates.
REQ-037 Wrap: with ADDRSIZE=4, preload rbin=30 and provide 4 words -> raddr sequence 14, 15, 0, 1; rptr gray sequence 10001, 10000, 00000, 00001; rempty=1 at the end.
REQ-038 Random dout_ready with a data-tagged stream of 200 words across multiple wraps -> order preserved, zero loss, ren never asserted while rempty=1.
REQ-039 rst pulsed low while occ=2 and inflt=1 -> all outputs at reset values within the same cycle; no stale word appears after release.

Source files
------------

// File: rtl/rd_side_ctrl.sv
`default_nettype none
// ============================================================================
// rd_side_ctrl : async-FIFO read-domain controller with a 2-entry prefetch
//                buffer (head + skid) feeding a valid/ready consumer port.
// Revision     : 1.0
// ============================================================================
module rd_side_ctrl #(
    parameter int ADDRSIZE = 4,
    parameter int DATASIZE = 8
) (
    input  logic                rclk,
    input  logic                rst,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                ren,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic                rempty,
    output logic [ADDRSIZE:0]   rcount,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready
);

    localparam int PW = ADDRSIZE + 1;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0]       rbin;
    logic [PW-1:0]       rbin_next;
    logic [PW-1:0]       rgray_next;
    logic [PW-1:0]       wbin_sync;
    logic [1:0]          occ;
    logic [1:0]          occ_next;
    logic [1:0]          arr_slot;
    logic [2:0]          fill;
    logic                inflt;
    logic                pop;
    logic [DATASIZE-1:0] head;
    logic [DATASIZE-1:0] skid;

    // Buffer demand after this cycle: what is held plus what is landing,
    // minus what the consumer takes. A read is issued only if room remains.
    always_comb begin
        pop        = dout_valid & dout_ready;
        fill       = {1'b0, occ} + {2'b00, inflt} - {2'b00, pop};
        ren        = ~rempty & (fill < 3'd2);
        occ_next   = fill[1:0];
        arr_slot   = occ - {1'b0, pop};
        rbin_next  = rbin + {{ADDRSIZE{1'b0}}, ren};
        rgray_next = (rbin_next >> 1) ^ rbin_next;
        wbin_sync  = gray2bin(rq2_wptr);
    end

    assign raddr      = rbin[ADDRSIZE-1:0];
    assign dout       = head;
    assign dout_valid = (occ != 2'd0);

    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
            rcount <= '0;
        end else begin
            rbin   <= rbin_next;
            rptr   <= rgray_next;
            rempty <= (rgray_next == rq2_wptr);
            rcount <= wbin_sync - rbin_next;
        end
    end

    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            inflt <= 1'b0;
            occ   <= 2'd0;
        end else begin
            inflt <= ren;
            occ   <= occ_next;
        end
    end

    // Pop shifts skid into head; an arriving word lands in the first free
    // slot after that shift, so order is preserved on simultaneous events.
    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (pop && (occ == 2'd2)) begin
                head <= skid;
            end
            if (inflt) begin
                if (arr_slot == 2'd0) begin
                    head <= mem_rdata;
                end else begin
                    skid <= mem_rdata;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rd_side_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rd_side_ctrl : scoreboard bench with a write-side/memory model.
// Revision        : 1.0
// ============================================================================
module tb_rd_side_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic          rclk = 1'b0;
    logic          rst  = 1'b0;
    logic [PW-1:0] rq2_wptr = '0;
    logic [PW-1:0] rptr;
    logic [AW-1:0] raddr;
    logic          ren;
    logic [DW-1:0] mem_rdata = '0;
    logic          rempty;
    logic [PW-1:0] rcount;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;

    rd_side_ctrl #(.ADDRSIZE(AW), .DATASIZE(DW)) dut (
        .rclk       (rclk),
        .rst        (rst),
        .rq2_wptr   (rq2_wptr),
        .rptr       (rptr),
        .raddr      (raddr),
        .ren        (ren),
        .mem_rdata  (mem_rdata),
        .rempty     (rempty),
        .rcount     (rcount),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 rclk = ~rclk;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_w;
    int checks   = 0;
    int passed   = 0;
    int wcnt     = 0;
    int consumed = 0;
    int ren_cnt  = 0;

    always @(posedge rclk) begin
        if (ren) mem_rdata <= mem[raddr];
    end

    function automatic logic [PW-1:0] gray(input int b);
        logic [PW-1:0] v;
        v = b[PW-1:0];
        return (v >> 1) ^ v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: every accepted word must be the oldest word still owed.
    always @(negedge rclk) begin
        if (rst) begin
            if (ren) begin
                ren_cnt++;
                check("ren_while_empty", int'(rempty), 0);
            end
            if (dout_valid && dout_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", int'(dout), -1);
                end else begin
                    exp_w = sb.pop_front();
                    check("dout_data", int'(dout), int'(exp_w));
                end
                consumed++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic push_words(input int n);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = DW'($urandom);
            mem[wcnt % DEPTH] = d;
            sb.push_back(d);
            wcnt++;
        end
        rq2_wptr = gray(wcnt);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((sb.size() != 0 || dout_valid) && t < 300) begin
            tick(1);
            t++;
        end
        check({name, "_drain_in_time"}, int'(t < 300), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int first_ren, first_v, k, c0, guard;

        tick(3);
        check("rst_rempty", int'(rempty), 1);
        check("rst_ren", int'(ren), 0);
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_rcount", int'(rcount), 0);
        check("rst_rptr", int'(rptr), 0);
        check("rst_dout", int'(dout), 0);
        rst = 1'b1;
        tick(6);
        check("idle_rempty", int'(rempty), 1);
        check("idle_ren", int'(ren), 0);
        check("idle_dout_valid", int'(dout_valid), 0);
        check("idle_rcount", int'(rcount), 0);

        // Three words appear at once
        ren_cnt = 0;
        dout_ready = 1'b1;
        push_words(3);
        first_ren = -1;
        first_v   = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge rclk);
            if (ren && first_ren < 0) first_ren = c;
            if (dout_valid && first_v < 0) first_v = c;
        end
        check("latency_ren_to_valid", first_v - first_ren, 2);
        drain("three");
        check("three_ren_count", ren_cnt, 3);
        check("three_rptr", int'(rptr), int'(gray(3)));
        check("three_rempty", int'(rempty), 1);

        // Full FIFO with stalled consumer, then full-rate drain
        dout_ready = 1'b0;
        ren_cnt = 0;
        push_words(16);
        tick(10);
        check("stall_reads_issued", ren_cnt, 2);
        check("stall_rcount", int'(rcount), 14);
        check("stall_dout_valid", int'(dout_valid), 1);
        c0 = consumed;
        dout_ready = 1'b1;
        tick(16);
        check("full_rate_pops", consumed - c0, 16);
        drain("full");

        // Bring read pointer to 30, then cross the wrap point
        push_words(11);
        drain("prewrap");
        push_words(4);
        k = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge rclk);
            if (ren) begin
                check("wrap_raddr", int'(raddr), (30 + k) % DEPTH);
                check("wrap_rptr", int'(rptr), int'(gray(30 + k)));
                k++;
            end
        end
        check("wrap_read_count", k, 4);
        drain("wrap");
        tick(2);
        check("wrap_rempty", int'(rempty), 1);

        // Random producer and consumer, 200 words
        c0 = wcnt;
        guard = 0;
        while (wcnt - c0 < 200 && guard < 5000) begin
            tick(1);
            guard++;
            dout_ready = ($urandom_range(0, 3) != 0);
            if ((wcnt - consumed) < DEPTH && $urandom_range(0, 2) != 0) push_words(1);
        end
        check("random_all_written", wcnt - c0, 200);
        dout_ready = 1'b1;
        drain("random");

        // Reset in the middle of a stream
        push_words(10);
        tick(4);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_dout_valid", int'(dout_valid), 0);
        check("midrst_ren", int'(ren), 0);
        check("midrst_rempty", int'(rempty), 1);
        check("midrst_rcount", int'(rcount), 0);
        check("midrst_rptr", int'(rptr), 0);
        check("midrst_dout", int'(dout), 0);
        sb.delete();
        wcnt = 0;
        consumed = 0;
        rq2_wptr = '0;
        tick(3);
        rst = 1'b1;
        tick(3);
        check("postrst_dout_valid", int'(dout_valid), 0);
        check("postrst_rempty", int'(rempty), 1);
        push_words(3);
        drain("postrst");
        check("postrst_consumed", consumed, 3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
